float16_acc: RTL and testbench

Windowed half-precision accumulator for the convolution datapath. It sits directly downstream of `float16_mul` and consumes that block's `de_out`/`data_out` product stream. It sums each group of `KERNEL_LEN` valid products (one kernel window, e.g. a 3x3 patch) and emits one fp16 result per window. The result feeds the activation/write-back stage.

---
 rtl/float16_pkg.sv | 19 +
 rtl/float16_add.sv | 97 +++++++++
 rtl/float16_acc.sv | 58 +++++
 tb/tb_float16_acc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/float16_pkg.sv
// Shared fp16 field widths, special encodings and the unpacked-fields view.
// Used by float16_acc/float16_add and by the upstream float16_mul.
package float16_pkg;

  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP16_BIAS   = 15;

  localparam logic [15:0] FP16_POS_MAX = 16'h7BFF;
  localparam logic [15:0] FP16_NEG_MAX = 16'hFBFF;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/float16_add.sv
// Combinational fp16 adder: FTZ inputs/outputs, exp=31 read as max finite,
// GRS alignment, 14-bit LZC normalization, RNE rounding, saturation.
module float16_add
  import float16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  fp16_t              fa, fb;
  logic [10:0]        ma, mb, m_big, m_small;
  logic [4:0]         ea, eb, e_big, e_small, diff;
  logic               s_big, eff_sub;
  logic [31:0]        sh;
  logic [13:0]        big_ext, small_ext, norm;
  logic [14:0]        raw;
  logic [3:0]         lz;
  logic signed [6:0]  e_n;
  logic [11:0]        mant_r;
  logic               rnd;

  assign fa = fp16_t'(a);
  assign fb = fp16_t'(b);

  always_comb begin
    ea = fa.exp;
    ma = {1'b1, fa.frac};
    if (fa.exp == 5'd0) begin
      ea = 5'd0;
      ma = 11'd0;
    end else if (fa.exp == 5'd31) begin
      ea = 5'd30;
      ma = 11'h7FF;
    end
    eb = fb.exp;
    mb = {1'b1, fb.frac};
    if (fb.exp == 5'd0) begin
      eb = 5'd0;
      mb = 11'd0;
    end else if (fb.exp == 5'd31) begin
      eb = 5'd30;
      mb = 11'h7FF;
    end
  end

  always_comb begin
    if ({ea, ma} >= {eb, mb}) begin
      e_big = ea; m_big = ma; s_big = fa.sign;
      e_small = eb; m_small = mb;
    end else begin
      e_big = eb; m_big = mb; s_big = fb.sign;
      e_small = ea; m_small = ma;
    end
    eff_sub = fa.sign ^ fb.sign;
    diff    = e_big - e_small;
    // Bits pushed below the round bit collapse into the sticky bit.
    sh        = {m_small, 3'b000, 18'd0} >> diff;
    small_ext = {sh[31:19], sh[18] | (|sh[17:0])};
    big_ext   = {m_big, 3'b000};
    raw = eff_sub ? ({1'b0, big_ext} - {1'b0, small_ext})
                  : ({1'b0, big_ext} + {1'b0, small_ext});
  end

  always_comb begin
    lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (raw[i]) lz = 4'(13 - i);
    end
  end

  always_comb begin
    norm   = 14'd0;
    e_n    = 7'sd0;
    rnd    = 1'b0;
    mant_r = 12'd0;
    sum    = FP16_ZERO;
    if (raw[14]) begin
      norm = {raw[14:2], raw[1] | raw[0]};
      e_n  = signed'({2'b00, e_big}) + 7'sd1;
    end else begin
      norm = raw[13:0] << lz;
      e_n  = signed'({2'b00, e_big}) - signed'({3'b000, lz});
    end
    rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[13:3]} + {11'd0, rnd};
    if (mant_r[11]) e_n = e_n + 7'sd1;
    if (raw == 15'd0 || e_n <= 7'sd0) begin
      sum = FP16_ZERO;
    end else if (e_n >= 7'sd31) begin
      sum = s_big ? FP16_NEG_MAX : FP16_POS_MAX;
    end else begin
      sum = {s_big, e_n[4:0], mant_r[11] ? mant_r[10:1] : mant_r[9:0]};
    end
  end

endmodule

// File: rtl/float16_acc.sv
// Windowed fp16 accumulator: sums KERNEL_LEN valid products per window and
// emits one registered result pulse per completed window.
module float16_acc
  import float16_pkg::*;
#(
  parameter int KERNEL_LEN = 9
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        clr,
  input  logic        de_in,
  input  logic [15:0] data_in,
  output logic        de_out,
  output logic [15:0] data_out
);

  localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;

  logic [CNT_W-1:0] cnt;
  logic [15:0]      acc, add_b, add_sum;
  logic             first, last;

  // clr alongside a valid sample makes that sample element 0 of a new window.
  assign first = clr || (cnt == '0);
  assign last  = !clr && (cnt == CNT_W'(KERNEL_LEN - 1));
  assign add_b = first ? FP16_ZERO : acc;

  float16_add u_add (
    .a   (data_in),
    .b   (add_b),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt      <= '0;
      acc      <= FP16_ZERO;
      de_out   <= 1'b0;
      data_out <= FP16_ZERO;
    end else begin
      de_out <= 1'b0;
      if (de_in) begin
        acc <= add_sum;
        if (last) begin
          cnt      <= '0;
          data_out <= add_sum;
          de_out   <= 1'b1;
        end else begin
          cnt <= first ? CNT_W'(1) : cnt + CNT_W'(1);
        end
      end else if (clr) begin
        cnt <= '0;
        acc <= FP16_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_float16_acc.sv
// Bench for float16_acc: directed test-plan cases plus randomized traffic
// checked against a real-arithmetic windowed-sum model.
module tb_float16_acc;

  localparam int KLEN = 9;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        clr = 1'b0;
  logic        de_in = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        de_out;
  logic [15:0] data_out;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cycle = 0;
  int          n_pulse = 0;
  int          first_pulse = 0;
  int          last_pulse = 0;

  int          m_cnt = 0;
  logic [15:0] m_acc = 16'h0000;
  logic [15:0] m_out = 16'h0000;
  logic        m_de = 1'b0;

  float16_acc #(.KERNEL_LEN(KLEN)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .clr      (clr),
    .de_in    (de_in),
    .data_in  (data_in),
    .de_out   (de_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic real pow2(int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(logic [15:0] x);
    real mag;
    if (x[14:10] == 5'd0) return 0.0;
    if (x[14:10] == 5'd31) mag = 65504.0;
    else mag = (1.0 + real'(x[9:0]) / 1024.0) * pow2(int'(x[14:10]) - 15);
    return x[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] r2f(real x);
    logic s;
    real  m, q, rem;
    int   e, fl;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    if (e < -14) return 16'h0000;
    q   = m * 1024.0;
    fl  = $rtoi(q);
    rem = q - real'(fl);
    if (rem > 0.5 || (rem == 0.5 && fl[0])) fl++;
    if (fl == 2048) begin fl = 1024; e++; end
    if (e > 15) return s ? 16'hFBFF : 16'h7BFF;
    return {s, 5'(e + 15), 10'(fl - 1024)};
  endfunction

  function automatic logic [15:0] rand_fp16();
    int r;
    logic [4:0] e;
    r = $urandom_range(0, 15);
    if (r == 0) e = 5'd0;
    else if (r == 1) e = 5'd31;
    else e = 5'($urandom_range(8, 22));
    return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic cyc(input logic de, input logic [15:0] d, input logic c);
    de_in   = de;
    data_in = d;
    clr     = c;
    @(posedge clk);
    #1;
    cycle++;
    m_de = 1'b0;
    if (c) m_cnt = 0;
    if (de) begin
      m_acc = (m_cnt == 0) ? r2f(f2r(d)) : r2f(f2r(m_acc) + f2r(d));
      if (m_cnt == KLEN - 1) begin
        m_de  = 1'b1;
        m_out = m_acc;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    chk("de_out", 16'(de_out), 16'(m_de));
    chk("data_out", data_out, m_out);
    if (de_out) begin
      n_pulse++;
      if (n_pulse == 1) first_pulse = cycle;
      last_pulse = cycle;
    end
    de_in = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #3;
    m_cnt = 0;
    m_acc = 16'h0000;
    m_out = 16'h0000;
    m_de  = 1'b0;
    chk("rst_de_out", 16'(de_out), 16'h0000);
    chk("rst_data_out", data_out, 16'h0000);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  initial begin
    do_reset();
    cyc(1'b0, 16'h0000, 1'b0);

    // unit sum
    n_pulse = 0;
    repeat (KLEN) cyc(1'b1, 16'h3C00, 1'b0);
    chk("unit_pulse", 16'(de_out), 16'h0001);
    chk("unit_sum", data_out, 16'h4880);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("unit_pulse_once", 16'(n_pulse), 16'd1);

    // cancellation
    cyc(1'b1, 16'h3C00, 1'b0);
    cyc(1'b1, 16'hBC00, 1'b0);
    repeat (7) cyc(1'b1, 16'h0000, 1'b0);
    chk("cancel", data_out, 16'h0000);

    // rounding: tie to even, then tie rounding up to even
    cyc(1'b1, 16'h6800, 1'b0);
    cyc(1'b1, 16'h3C00, 1'b0);
    repeat (7) cyc(1'b1, 16'h0000, 1'b0);
    chk("round_tie_even", data_out, 16'h6800);
    cyc(1'b1, 16'h6800, 1'b0);
    cyc(1'b1, 16'h4200, 1'b0);
    repeat (7) cyc(1'b1, 16'h0000, 1'b0);
    chk("round_2052", data_out, 16'h6802);

    // saturation with gaps
    n_pulse = 0;
    for (int i = 0; i < KLEN; i++) begin
      cyc(1'b1, 16'h7BFF, 1'b0);
      if (i < KLEN - 1) repeat (2) cyc(1'b0, 16'h0000, 1'b0);
    end
    chk("sat_value", data_out, 16'h7BFF);
    repeat (3) cyc(1'b0, 16'h0000, 1'b0);
    chk("sat_pulses", 16'(n_pulse), 16'd1);
    chk("sat_hold", data_out, 16'h7BFF);

    // back-to-back windows
    n_pulse = 0;
    repeat (2 * KLEN) cyc(1'b1, 16'h3C00, 1'b0);
    chk("b2b_pulses", 16'(n_pulse), 16'd2);
    chk("b2b_spacing", 16'(last_pulse - first_pulse), 16'(KLEN));
    chk("b2b_value", data_out, 16'h4880);

    // clr abort coincident with a sample
    repeat (4) cyc(1'b1, 16'h3C00, 1'b0);
    n_pulse = 0;
    cyc(1'b1, 16'h4000, 1'b1);
    repeat (KLEN - 1) cyc(1'b1, 16'h3C00, 1'b0);
    chk("clr_value", data_out, 16'h4900);
    chk("clr_pulses", 16'(n_pulse), 16'd1);

    // reset mid-window
    repeat (4) cyc(1'b1, 16'h4000, 1'b0);
    do_reset();
    repeat (KLEN) cyc(1'b1, 16'h3C00, 1'b0);
    chk("rst_mid_value", data_out, 16'h4880);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), rand_fp16(), 1'($urandom_range(0, 19) == 0));
    end
    repeat (3) cyc(1'b0, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
